// File: rtl/lmsm_sequencer_pkg.sv
// lmsm_sequencer_pkg: shared pipeline constants and state encoding for the LM/SM sequencer
package lmsm_sequencer_pkg;
  localparam logic [3:0] OPC_LM = 4'b1100;
  localparam logic [3:0] OPC_SM = 4'b1101;
  localparam int NSLOT = 7;
  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;
endpackage

// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: decode-to-register-read stage signals of the LM/SM sequencer
interface lmsm_sequencer_if;
  logic [15:0] instr_id;
  logic valid_id;
  logic stall_in;
  logic flush;
  logic [15:0] instr_rr;
  logic valid_rr;
  logic [2:0] k_rr;
  logic [2:0] off_rr;
  logic hold_if;
  modport master (
    output instr_id, valid_id, stall_in, flush,
    input instr_rr, valid_rr, k_rr, off_rr, hold_if
  );
  modport slave (
    input instr_id, valid_id, stall_in, flush,
    output instr_rr, valid_rr, k_rr, off_rr, hold_if
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands LM/SM into NSLOT micro-ops, passing other instructions through
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
#(
  parameter logic [3:0] OPC_LM = lmsm_sequencer_pkg::OPC_LM,
  parameter logic [3:0] OPC_SM = lmsm_sequencer_pkg::OPC_SM,
  parameter int NSLOT = lmsm_sequencer_pkg::NSLOT
) (
  input logic clk,
  input logic rst,
  lmsm_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n, ones, ones_n, k_n, off_n, idx;
  logic [15:0] instr_n;
  logic valid_n, is_ms, last;
  assign is_ms = bus.valid_id && (bus.instr_id[15:12] == OPC_LM || bus.instr_id[15:12] == OPC_SM);
  assign last = cnt == 3'(NSLOT - 1);
  assign idx = 3'(NSLOT - 1) - cnt;
  // instr_rr doubles as the latched LM/SM word for the whole sequence
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ones_n = ones;
    instr_n = bus.instr_rr;
    valid_n = bus.valid_rr;
    k_n = bus.k_rr;
    off_n = bus.off_rr;
    bus.hold_if = !rst && !bus.flush && (state == SEQ ? !last : is_ms);
    if (bus.flush) begin
      state_n = IDLE;
      valid_n = 1'b0;
      cnt_n = 3'd0;
      ones_n = 3'd0;
    end else if (!bus.stall_in && state == SEQ) begin
      valid_n = 1'b1;
      k_n = cnt;
      off_n = ones;
      cnt_n = last ? 3'd0 : cnt + 3'd1;
      ones_n = last ? 3'd0 : ones + {2'b0, bus.instr_rr[idx]};
      state_n = last ? IDLE : SEQ;
    end else if (!bus.stall_in) begin
      instr_n = bus.instr_id;
      valid_n = bus.valid_id;
      k_n = 3'd0;
      off_n = 3'd0;
      state_n = is_ms ? SEQ : IDLE;
      cnt_n = is_ms ? 3'd1 : 3'd0;
      ones_n = is_ms ? {2'b0, bus.instr_id[NSLOT-1]} : 3'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      ones <= 3'd0;
      bus.instr_rr <= 16'h0000;
      bus.valid_rr <= 1'b0;
      bus.k_rr <= 3'd0;
      bus.off_rr <= 3'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ones <= ones_n;
      bus.instr_rr <= instr_n;
      bus.valid_rr <= valid_n;
      bus.k_rr <= k_n;
      bus.off_rr <= off_n;
    end
  end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed scenarios plus random traffic against a cycle-level reference model
module tb_lmsm_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  lmsm_sequencer_if bus();
  lmsm_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  logic [15:0] cur = 16'h0;
  int nk = 0;
  bit busy = 0, known = 0;
  logic [15:0] e_instr = 16'h0;
  logic e_valid = 1'b0;
  int e_k = 0, e_off = 0;
  logic [15:0] obs_instr;
  logic obs_valid, obs_hold;
  int obs_k, obs_off;
  int ks[14], offs[14];
  int hc, vc;
  int exp_off[7] = '{0, 1, 1, 2, 2, 2, 3};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_ms(input logic [15:0] w);
    return w[15:12] == 4'hC || w[15:12] == 4'hD;
  endfunction

  function automatic int above(input logic [15:0] w, input int k);
    int c = 0;
    for (int i = 0; i < 7; i++) if (i > 6 - k && w[i]) c++;
    return c;
  endfunction

  task automatic step(input logic r, input logic [15:0] ins, input logic v, input logic st, input logic fl);
    logic eh;
    rst = r;
    bus.instr_id = ins;
    bus.valid_id = v;
    bus.stall_in = st;
    bus.flush = fl;
    #3;
    eh = !r && !fl && (busy ? nk < 6 : (v && is_ms(ins)));
    obs_hold = bus.hold_if;
    check("hold_if", {15'b0, bus.hold_if}, {15'b0, eh});
    if (r) begin
      e_instr = 16'h0; e_valid = 0; e_k = 0; e_off = 0; busy = 0; known = 1;
    end else if (fl) begin
      e_valid = 0; busy = 0; known = 0;
    end else if (st) begin
    end else if (busy) begin
      e_instr = cur; e_valid = 1; e_k = nk; e_off = above(cur, nk);
      nk++;
      if (nk == 7) busy = 0;
    end else if (v && is_ms(ins)) begin
      cur = ins; e_instr = ins; e_valid = 1; e_k = 0; e_off = 0; busy = 1; nk = 1; known = 1;
    end else begin
      e_instr = ins; e_valid = v; e_k = 0; e_off = 0; known = 1;
    end
    @(posedge clk);
    #1;
    obs_instr = bus.instr_rr;
    obs_valid = bus.valid_rr;
    obs_k = int'(bus.k_rr);
    obs_off = int'(bus.off_rr);
    check("valid_rr", {15'b0, bus.valid_rr}, {15'b0, e_valid});
    if (known) begin
      check("instr_rr", bus.instr_rr, e_instr);
      check("k_rr", {13'b0, bus.k_rr}, 16'(e_k));
      check("off_rr", {13'b0, bus.off_rr}, 16'(e_off));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_id = 16'h0; bus.valid_id = 0; bus.stall_in = 0; bus.flush = 0;
    @(posedge clk);
    #1;
    step(1, 16'hC053, 1, 0, 0);
    step(1, 16'h0000, 0, 0, 0);
    check("reset_instr", obs_instr, 16'h0000);
    check("reset_valid", {15'b0, obs_valid}, 16'h0);
    hc = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 16'hC053, 1, 0, 0);
      ks[i] = obs_k; offs[i] = obs_off; hc += int'(obs_hold);
    end
    for (int i = 0; i < 7; i++) begin
      check("c053_k", 16'(ks[i]), 16'(i));
      check("c053_off", 16'(offs[i]), 16'(exp_off[i]));
    end
    check("c053_hold_cycles", 16'(hc), 16'd6);
    step(0, 16'h1234, 1, 0, 0);
    check("pass_instr", obs_instr, 16'h1234);
    check("pass_valid", {15'b0, obs_valid}, 16'h1);
    check("pass_hold", {15'b0, obs_hold}, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 16'hD07F, 1, 0, 0);
    step(0, 16'hD07F, 1, 1, 0);
    step(0, 16'hD07F, 1, 1, 0);
    check("stall_k_held", 16'(obs_k), 16'd2);
    for (int i = 0; i < 4; i++) begin
      step(0, 16'hD07F, 1, 0, 0);
      check("sm_off", 16'(obs_off), 16'(3 + i));
    end
    for (int i = 0; i < 4; i++) step(0, 16'hC053, 1, 0, 0);
    step(0, 16'hC053, 1, 0, 1);
    check("flush_valid", {15'b0, obs_valid}, 16'h0);
    check("flush_hold", {15'b0, obs_hold}, 16'h0);
    step(0, 16'h2345, 1, 0, 0);
    check("flush_then_idle", obs_instr, 16'h2345);
    for (int i = 0; i < 3; i++) step(0, 16'hC053, 1, 0, 0);
    step(1, 16'hC053, 1, 0, 0);
    check("mid_reset_instr", obs_instr, 16'h0000);
    check("mid_reset_k", 16'(obs_k), 16'd0);
    vc = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0000, 0, 0, 0);
      vc += int'(obs_valid);
    end
    check("no_uops_after_reset", 16'(vc), 16'd0);
    vc = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, i < 7 ? 16'hC001 : 16'hD040, 1, 0, 0);
      ks[i] = obs_k; vc += int'(obs_valid);
    end
    check("b2b_valid_count", 16'(vc), 16'd14);
    check("b2b_first_last_k", 16'(ks[6]), 16'd6);
    check("b2b_second_first_k", 16'(ks[7]), 16'd0);
    check("b2b_second_last_k", 16'(ks[13]), 16'd6);
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[15:12] = {3'b110, 1'($urandom)};
      step($urandom_range(0, 99) == 0, w, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 Parameter OPC_LM, default 4'b1100, opcode of load-multiple.
REQ-002 Parameter OPC_SM, default 4'b1101, opcode of store-multiple.
REQ-003 Parameter NSLOT, default 7, number of register-list bits (micro-ops per LM/SM).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr_id  in  16  instruction held in the IF/ID register; opcode [15:12], register list [6:0].
REQ-007 valid_id  in  1  instr_id is valid.
REQ-008 stall_in  in  1  downstream hazard stall; freezes this block.
REQ-009 flush  in  1  branch/jump flush of the decode stage.
REQ-010 instr_rr  out  16  registered instruction or micro-op to the next stage.
REQ-011 valid_rr  out  1  instr_rr is valid.
REQ-012 k_rr  out  3  micro-op index 0..6; the memory-stage write-kill logic tests list bit [6-k].
REQ-013 off_rr  out  3  address offset: count of set list bits above the current one.
REQ-014 hold_if  out  1  combinational; keeps IF/ID and PC frozen while the sequence is generated.

Function
REQ-015 The FSM SHALL have two states: IDLE and SEQ. A 3-bit counter cnt SHALL hold the next k, and a 3-bit counter ones SHALL hold the running set-bit count.
REQ-016 In IDLE, a non-LM/SM instruction with stall_in=0 SHALL be passed with 1-cycle latency: instr_rr<=instr_id, valid_rr<=valid_id, k_rr<=0, off_rr<=0.
REQ-017 In IDLE, valid_id=1 with an LM/SM opcode, stall_in=0 and flush=0 (acceptance) SHALL latch instr_id and issue k=0 with off=0. It SHALL then set cnt<=1, set ones<=instr_id[6] and enter SEQ.
REQ-018 In SEQ, each cycle with stall_in=0 SHALL issue the latched instruction with k_rr<=cnt, off_rr<=ones and valid_rr<=1. It SHALL then update cnt<=cnt+1 and ones<=ones+list[6-cnt].
REQ-019 The cycle that issues k=6 SHALL return the FSM to IDLE. Exactly 7 micro-ops SHALL be issued on 7 consecutive non-stalled cycles.
REQ-020 hold_if SHALL be 1 in the acceptance cycle and in SEQ while cnt<6. It SHALL be 0 in the k=6 issue cycle so that IF/ID advances on the same edge. Total hold is 6 non-stalled cycles.
REQ-021 An all-zero register list SHALL still produce 7 micro-ops with off_rr=0; the write-kill logic discards them.
REQ-022 When stall_in=1 and flush=0, every register SHALL hold its value, and hold_if SHALL keep its current-state value.
REQ-023 flush=1 SHALL take priority over stall_in and acceptance: next state IDLE, valid_rr<=0, cnt<=0, ones<=0, hold_if=0 in that cycle.
REQ-024 off_rr SHALL never exceed 6, and cnt SHALL never exceed 6; no wrap-around is permitted.
REQ-025 An LM/SM instruction directly following another SHALL be accepted in the first IDLE cycle, with no bubble.

Reset
REQ-026 With rst=1 at a clock edge: state IDLE, cnt=0, ones=0, instr_rr=16'h0000, valid_rr=0, k_rr=0, off_rr=0.
REQ-027 hold_if SHALL be 0 while rst=1.
REQ-028 Reset asserted mid-sequence SHALL abandon the sequence with no further micro-ops.

Structure
REQ-029 OPC_LM, OPC_SM, NSLOT and the state encoding (IDLE=0, SEQ=1) SHALL reside in the shared pipeline package.
REQ-030 The block SHALL be a single module with no sub-modules. The set-bit count SHALL be incremental, with no full popcount tree.

Verification
REQ-031 Verification SHALL cover these directed scenarios:
- LM instr_id=16'hC053 (list 1010011), no stalls -> k_rr 0..6 on consecutive cycles, off_rr 0,1,1,2,2,2,3, hold_if high for 6 cycles.
- Non-LM/SM 16'h1234 with valid_id=1 -> instr_rr=16'h1234, valid_rr=1, k_rr=0 one cycle later, hold_if=0.
- SM 16'hD07F with stall_in=1 for 2 cycles after k=2 -> k=2 held 3 cycles, then k=3..6 with off_rr 3,4,5,6.
- flush=1 while k=4 is issuing -> valid_rr=0 next cycle, hold_if=0, FSM in IDLE.
- rst=1 during SEQ at k=3 -> all outputs at reset values next cycle, no further micro-ops.
- Back-to-back 16'hC001 then 16'hD040 -> 14 contiguous micro-ops, second k=0 immediately after first k=6.
